// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multi-cycle RV32 core: FSM states,
// opcode values, ALU operation codes and immediate formats.
package riscv_mc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SUB = 3'b010,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_t;

    // Sign-extended immediate; B and J carry an implicit zero LSB.
    function automatic logic [31:0] imm_gen(input logic [31:7] ir, input imm_fmt_t fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/riscv_mc_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, synchronous active-low clear, x0 hardwired to zero.
module riscv_mc_regfile #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          areset,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd
);
    logic [31:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!areset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I/RV32E subset core with a single shared memory port.
// FSM, immediate generation and ALU live here; registers in riscv_mc_regfile.
module riscv_mc_core
    import riscv_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        areset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        retire,
    output logic        halted,
    output logic        illegal,
    output state_t      dbg_state
);
    localparam int AW = $clog2(NREGS);

    state_t      state;
    logic [31:0] pc, ir, a, b, tgt, alu_out, mdr;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm, src_b, alu_res, ea, pc_plus4;
    logic        legal, is_ebreak, use_rs1, use_rs2, use_rd, bad_reg, dec_illegal, br_taken;
    imm_fmt_t    fmt;
    alu_op_t     alu_op;

    assign opcode   = ir[6:0];
    assign f3       = ir[14:12];
    assign f7       = ir[31:25];
    assign rs1      = ir[19:15];
    assign rs2      = ir[24:20];
    assign rd       = ir[11:7];
    assign imm      = imm_gen(ir[31:7], fmt);
    assign ea       = a + imm;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        legal     = 1'b0;
        is_ebreak = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        fmt       = IMM_I;
        case (opcode)
            OP_R: begin
                legal   = ((f7 == 7'b0000000) && (f3 != 3'b010) && (f3 != 3'b011)) ||
                          ((f7 == 7'b0100000) && (f3 == 3'b000));
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            OP_I: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111) ||
                          (((f3 == 3'b001) || (f3 == 3'b101)) && (f7 == 7'b0000000));
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_LW: begin
                legal   = (f3 == 3'b010);
                use_rs1 = 1'b1; use_rd = 1'b1;
            end
            OP_SW: begin
                legal   = (f3 == 3'b010);
                fmt     = IMM_S;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_BR: begin
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100);
                fmt     = IMM_B;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JAL: begin
                legal  = 1'b1;
                fmt    = IMM_J;
                use_rd = 1'b1;
            end
            OP_SYS:  is_ebreak = (ir == EBREAK_INSN);
            default: legal = 1'b0;
        endcase
    end

    // RV32E has no x16..x31; only the fields an instruction actually uses count.
    assign bad_reg     = (NREGS == 16) && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
    assign dec_illegal = !(legal || is_ebreak) || bad_reg;

    assign alu_op = ((opcode == OP_R) && f7[5] && (f3 == 3'b000)) ? ALU_SUB : alu_op_t'(f3);
    assign src_b  = (opcode == OP_R) ? b : imm;

    always_comb begin
        case (alu_op)
            ALU_SLL: alu_res = a << src_b[4:0];
            ALU_SUB: alu_res = a - src_b;
            ALU_XOR: alu_res = a ^ src_b;
            ALU_SRL: alu_res = a >> src_b[4:0];
            ALU_OR:  alu_res = a | src_b;
            ALU_AND: alu_res = a & src_b;
            default: alu_res = a + src_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  br_taken = (a == b);
            3'b001:  br_taken = (a != b);
            default: br_taken = ($signed(a) < $signed(b));
        endcase
    end

    riscv_mc_regfile #(.NREGS(NREGS)) u_rf (
        .clk    (clk),
        .areset (areset),
        .ra1    (rs1[AW-1:0]),
        .ra2    (rs2[AW-1:0]),
        .rd1    (rs1_val),
        .rd2    (rs2_val),
        .we     (state == WB),
        .wa     (rd[AW-1:0]),
        .wd     ((opcode == OP_LW) ? mdr : alu_out)
    );

    // Memory handshake: mem_req is registered; while it is high, mem_we,
    // mem_addr and mem_wdata stay fixed, and the access completes on the first
    // edge with mem_req && mem_ready. mem_req is cleared by that same edge, and
    // after a store the next fetch waits one idle cycle so requests never abut.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            tgt       <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            illegal   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    a   <= rs1_val;
                    b   <= rs2_val;
                    tgt <= pc + imm;
                    if (dec_illegal) begin
                        illegal <= 1'b1;
                        state   <= HALT;
                    end else if (is_ebreak) begin
                        state <= HALT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        alu_out <= ea;
                        if (ea[1:0] != 2'b00) begin
                            illegal <= 1'b1;
                            state   <= HALT;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= (opcode == OP_SW);
                            mem_addr  <= ea;
                            mem_wdata <= b;
                            state     <= MEM;
                        end
                    end else if ((opcode == OP_BR) && br_taken || (opcode == OP_JAL)) begin
                        if (tgt[1:0] != 2'b00) begin
                            illegal <= 1'b1;
                            state   <= HALT;
                        end else if (opcode == OP_JAL) begin
                            alu_out <= pc_plus4;
                            pc      <= tgt;
                            state   <= WB;
                        end else begin
                            pc       <= tgt;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= tgt;
                            state    <= FETCH;
                        end
                    end else if (opcode == OP_BR) begin
                        pc       <= pc_plus4;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_plus4;
                        state    <= FETCH;
                    end else begin
                        alu_out <= alu_res;
                        state   <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            pc    <= pc_plus4;
                            state <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    pc       <= (opcode == OP_JAL) ? pc : pc_plus4;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= (opcode == OP_JAL) ? pc : pc_plus4;
                    state    <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    assign retire = (state == WB) ||
                    ((state == EXEC) && (opcode == OP_BR) && !(br_taken && (tgt[1:0] != 2'b00))) ||
                    ((state == MEM) && mem_we && mem_ready);
    assign halted    = (state == HALT);
    assign dbg_state = state;

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: hand-encoded programs in a wait-state
// memory model, cycle counts, register results, halts and mid-access reset.
module tb_riscv_mc_core;
    import riscv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        areset;
    logic        mem_req, mem_we, mem_ready, retire, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    state_t      dbg_state;

    logic        mem_req_e, mem_we_e, retire_e, halted_e, illegal_e;
    logic [31:0] mem_addr_e, mem_wdata_e;
    logic        mem_ready_e = 1'b1;
    logic [31:0] mem_rdata_e = 32'h00100A13;  // addi x20,x0,1: rd out of range on RV32E
    state_t      dbg_state_e;

    logic [31:0] imem [128];
    logic [31:0] dmem [128];
    bit          dvalid [128];
    int          wait_n;
    int          wcnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fetch_addr, st_addr, st_data;
    int          st_n;
    bit          st_unstable;

    always #5 clk = ~clk;

    riscv_mc_core #(.RESET_PC(32'h100), .NREGS(32)) dut (
        .clk(clk), .areset(areset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .retire(retire), .halted(halted),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    riscv_mc_core #(.RESET_PC(32'h100), .NREGS(16)) dut_e (
        .clk(clk), .areset(areset), .mem_req(mem_req_e), .mem_we(mem_we_e),
        .mem_addr(mem_addr_e), .mem_wdata(mem_wdata_e), .mem_ready(mem_ready_e),
        .mem_rdata(mem_rdata_e), .retire(retire_e), .halted(halted_e),
        .illegal(illegal_e), .dbg_state(dbg_state_e)
    );

    // Memory model: wait_n wait cycles per access, stores land in dmem.
    assign mem_ready = (wcnt == wait_n);
    assign mem_rdata = dvalid[mem_addr[8:2]] ? dmem[mem_addr[8:2]] : imem[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) begin
            dmem[mem_addr[8:2]]   <= mem_wdata;
            dvalid[mem_addr[8:2]] <= 1'b1;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction: counts cycles from its fetch request to retire.
    task automatic exec_one(output int cyc, output int lead);
        bit started;
        started     = 1'b0;
        cyc         = 0;
        lead        = 0;
        st_n        = 0;
        st_unstable = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!started && mem_req) begin
                started    = 1'b1;
                fetch_addr = mem_addr;
            end
            if (started) cyc++;
            else         lead++;
            if (mem_req && mem_we) begin
                if (st_n == 0) begin
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                end else if (mem_addr !== st_addr || mem_wdata !== st_data) begin
                    st_unstable = 1'b1;
                end
                st_n++;
            end
            if (retire === 1'b1) break;
        end
        if (retire !== 1'b1) cyc = -1;
    endtask

    task automatic wait_halt(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic quiet_window(output int reqs, output int rets, output int reqs_e);
        reqs = 0; rets = 0; reqs_e = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b0)   reqs++;
            if (retire !== 1'b0)    rets++;
            if (mem_req_e !== 1'b0) reqs_e++;
        end
    endtask

    task automatic restart(input logic [31:0] insn);
        areset = 1'b0;
        repeat (2) @(negedge clk);
        imem[64] = insn;
        areset = 1'b1;
    endtask

    initial begin
        int          cyc, lead, reqs, rets, reqs_e;
        bit          seen;
        logic [31:0] acc;

        areset = 1'b0;
        wait_n = 0;
        wcnt   = 0;
        for (int i = 0; i < 128; i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
        imem[64] = 32'h00500093;  // 0x100 addi x1,x0,5
        imem[65] = 32'h00700093;  // 0x104 addi x1,x0,7
        imem[66] = 32'hFFF00113;  // 0x108 addi x2,x0,-1
        imem[67] = 32'h002081B3;  // 0x10C add  x3,x1,x2
        imem[68] = 32'h40108233;  // 0x110 sub  x4,x1,x1
        imem[69] = 32'h00209333;  // 0x114 sll  x6,x1,x2
        imem[70] = 32'h001153B3;  // 0x118 srl  x7,x2,x1
        imem[71] = 32'h0F00C413;  // 0x11C xori x8,x1,0xF0
        imem[72] = 32'h00102423;  // 0x120 sw   x1,8(x0)
        imem[73] = 32'h00802283;  // 0x124 lw   x5,8(x0)
        imem[74] = 32'hEF9FF4EF;  // 0x128 jal  x9,0x20
        imem[8]  = 32'hFE114CE3;  // 0x020 blt  x2,x1,-8
        imem[6]  = 32'h00001463;  // 0x018 bne  x0,x0,+8
        imem[7]  = 32'h00100073;  // 0x01C ebreak

        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(FETCH));
        check("rst_pc", dut.pc, 32'h100);
        check("rst_flags", {29'd0, retire, halted, illegal}, 32'd0);
        areset = 1'b1;

        exec_one(cyc, lead);
        check("first_req_delay", 32'(lead), 32'd0);
        check("first_fetch_addr", fetch_addr, 32'h100);
        check("addi_cycles", 32'(cyc), 32'd4);
        exec_one(cyc, lead);
        check("addi_x1", dut.u_rf.regs[1], 32'd5);
        exec_one(cyc, lead);
        exec_one(cyc, lead);
        check("add_cycles", 32'(cyc), 32'd4);
        for (int i = 0; i < 4; i++) exec_one(cyc, lead);

        wait_n = 2;
        exec_one(cyc, lead);
        check("sw_cycles", 32'(cyc), 32'd8);
        check("sw_hold_cycles", 32'(st_n), 32'd3);
        check("sw_addr", st_addr, 32'h8);
        check("sw_data", st_data, 32'd7);
        check("sw_stable", {31'd0, st_unstable}, 32'd0);
        exec_one(cyc, lead);
        check("lw_cycles", 32'(cyc), 32'd9);
        wait_n = 0;

        exec_one(cyc, lead);
        check("jal_cycles", 32'(cyc), 32'd4);
        exec_one(cyc, lead);
        check("jal_target", fetch_addr, 32'h20);
        check("blt_cycles", 32'(cyc), 32'd3);
        exec_one(cyc, lead);
        check("blt_target", fetch_addr, 32'h18);
        check("bne_cycles", 32'(cyc), 32'd3);

        check("x1", dut.u_rf.regs[1], 32'd7);
        check("x2", dut.u_rf.regs[2], 32'hFFFF_FFFF);
        check("add_x3", dut.u_rf.regs[3], 32'd6);
        check("sub_x4", dut.u_rf.regs[4], 32'd0);
        check("lw_x5", dut.u_rf.regs[5], 32'd7);
        check("sll_x6", dut.u_rf.regs[6], 32'h8000_0000);
        check("srl_x7", dut.u_rf.regs[7], 32'h01FF_FFFF);
        check("xori_x8", dut.u_rf.regs[8], 32'h0000_00F7);
        check("jal_link_x9", dut.u_rf.regs[9], 32'h0000_012C);
        check("mem_word8", dmem[2], 32'd7);

        // Reset in the middle of a waited fetch.
        wait_n = 5;
        @(negedge clk);
        check("bne_fallthrough", mem_addr, 32'h1C);
        check("waited_fetch_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        check("abort_pc", dut.pc, 32'h100);
        acc = 32'h0;
        for (int i = 1; i < 32; i++) acc = acc | dut.u_rf.regs[i];
        check("abort_regs_zero", acc, 32'h0);
        wait_n = 0;

        restart(32'h00100073);  // ebreak
        wait_halt(seen);
        check("ebreak_halted", {31'd0, seen}, 32'd1);
        check("ebreak_illegal", {31'd0, illegal}, 32'd0);
        quiet_window(reqs, rets, reqs_e);
        check("ebreak_no_req", 32'(reqs + rets), 32'd0);

        restart(32'h0000007F);  // unknown opcode
        @(negedge clk);
        check("rst_clears_halted", {30'd0, halted, illegal}, 32'd0);
        wait_halt(seen);
        check("op7f_halted", {31'd0, seen}, 32'd1);
        check("op7f_illegal", {31'd0, illegal}, 32'd1);
        quiet_window(reqs, rets, reqs_e);
        check("op7f_no_req", 32'(reqs + rets), 32'd0);
        check("rv32e_halted", {30'd0, halted_e, illegal_e}, 32'd3);
        check("rv32e_no_req", 32'(reqs_e), 32'd0);

        restart(32'h00602283);  // lw x5,6(x0)
        wait_halt(seen);
        check("lw_misalign_halted", {31'd0, seen}, 32'd1);
        check("lw_misalign_illegal", {31'd0, illegal}, 32'd1);
        quiet_window(reqs, rets, reqs_e);
        check("lw_misalign_no_req", 32'(reqs + rets), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
